unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage fetch port and the MEM stage load/store port.
- Registers each granted request, drives a request/acknowledge memory handshake, and returns a one-cycle Ready pulse with read data.
- Lets IF_Stall/D_Stall freeze the pipeline while a port waits.
- Honours MEM-stage redirects (Flush = MEM_PCSrc) by discarding an in-flight fetch.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced. Legal range 1..15.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- IF_Req  in  1  fetch request; held with IF_Addr stable until IF_Ready.
- IF_Addr  in  ADDR_W  fetch address (PC).
- Flush  in  1  redirect (MEM_PCSrc); kills the outstanding fetch.
- IF_Ready  out  1  one-cycle pulse; IF_Rdata valid.
- IF_Rdata  out  DATA_W  fetched instruction, held until the next IF_Ready.
- IF_Stall  out  1  IF_Req & ~IF_Ready.
- D_Req  in  1  data request; held with its fields stable until D_Ready.
- D_We  in  1  1 = store, 0 = load.
- D_Addr  in  ADDR_W  data address.
- D_Wdata  in  DATA_W  store data.
- D_Be  in  DATA_W/8  byte enables.
- D_Ready  out  1  one-cycle completion pulse.
- D_Rdata  out  DATA_W  load data, held until the next load completes.
- D_Stall  out  1  D_Req & ~D_Ready.
- M_Req  out  1  memory request, registered.
- M_We  out  1  memory write enable, registered.
- M_Addr  out  ADDR_W  memory address, registered.
- M_Wdata  out  DATA_W  memory write data, registered.
- M_Be  out  DATA_W/8  memory byte enables, registered.
- M_Ack  in  1  memory completion, one cycle; M_Rdata valid with it.
- M_Rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE; M_Req, M_We, IF_Ready, D_Ready = 0.
  - M_Addr, M_Wdata, M_Be, IF_Rdata, D_Rdata = 0.
  - streak=0, drop=0.
  - Reset mid-transaction abandons it; M_Req falls immediately; no Ready is produced.
- FSM states: IDLE, FETCH, DATA.
- IDLE, eligibility:
  - A port is eligible if its Req=1 and its Ready output is 0 this cycle, which prevents re-grant in the Ready cycle.
  - Fetch is not eligible in a cycle where Flush=1.
- IDLE, arbitration:
  - Data wins, unless IF is eligible and streak==MAX_DSTREAK, in which case fetch wins.
  - On a grant, latch the port's fields into the M_* registers, set M_Req=1 (M_We=0, M_Be=all ones for fetch), and go to FETCH or DATA.
- FETCH/DATA:
  - M_Req and the fields stay stable until M_Ack.
  - On M_Ack: M_Req=0, capture M_Rdata, pulse the port's Ready next cycle, return to IDLE.
- Latency:
  - Request seen at cycle 0 → M_Req at cycle 1 → M_Ack at cycle k≥1 → Ready at cycle k+1.
  - M_Ack while M_Req=0 is ignored.
- Streak counter:
  - On a data grant with IF_Req=1: streak+1, saturating at MAX_DSTREAK.
  - On a fetch grant, or a data grant with IF_Req=0: streak=0.
- Flush:
  - In FETCH, or coincident with M_Ack in FETCH: set drop; on M_Ack, no IF_Ready and IF_Rdata unchanged; clear drop on return to IDLE.
  - In DATA or IDLE: no state effect.
- Stores: D_Rdata unchanged; D_Ready still pulses.
- Stall outputs are combinational; all other outputs are registered.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding (IDLE=2'd0, FETCH=2'd1, DATA=2'd2);
  - BE_W=DATA_W/8;
  - FETCH_BE constant (all ones).
- One natural sub-module: arb_streak_cnt, the saturating streak counter with compare output force_fetch.

Test Plan:
1. Fetch only, IF_Addr=0x0000_0040, M_Ack at cycle 1 with M_Rdata=0x2002_0005 → M_Req=1/M_We=0/M_Addr=0x40 at cycle 1; IF_Ready=1 and IF_Rdata=0x20020005 at cycle 2; IF_Stall=1 in cycles 0–1.
2. IF_Req (0x44) and load D_Req (0x100) in the same cycle → M_Addr=0x100 first, D_Ready; next grant is fetch 0x44; IF_Stall stays high until its IF_Ready.
3. IF_Req held high, D_Req continuous for 6 loads, MAX_DSTREAK=4 → grant order D,D,D,D,I,D,D.
4. Fetch 0x48 granted, Flush=1 at cycle 2, M_Ack at cycle 4 → no IF_Ready and IF_Rdata unchanged; new IF_Addr=0x200 granted next, returns normally.
5. Store D_Addr=0x300, D_Wdata=0xDEAD_BEEF, D_Be=4'b0011, Rst=1 asserted at cycle 2 before M_Ack → M_Req=0 in the same cycle, no D_Ready; after release, state IDLE, streak=0, and the re-presented store completes with M_Be=0011, M_We=1 and D_Rdata unchanged.
6. M_Ack pulsed with M_Req=0 in IDLE → no Ready pulse and no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the unified memory arbiter: FSM encoding and
// default bus geometry.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    // Instruction fetches always read the full word.
    localparam logic [BE_W-1:0] FETCH_BE = '1;

endpackage

// File: rtl/arb_streak_cnt.sv
// Counts consecutive data grants made while a fetch is waiting and raises
// force_fetch once the limit is reached, so fetch cannot be starved.
module arb_streak_cnt #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_data_grant,
    input  logic i_fetch_grant,
    input  logic i_if_req,
    output logic o_force_fetch
);

    localparam logic [3:0] MAXV = 4'(MAX_DSTREAK);

    logic [3:0] r_cnt;

    // Saturating count of data grants that overtook a pending fetch.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (i_fetch_grant) begin
            r_cnt <= '0;
        end else if (i_data_grant) begin
            if (!i_if_req)
                r_cnt <= '0;
            else if (r_cnt != MAXV)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force_fetch = (r_cnt == MAXV);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one
// single-port memory with a registered req/ack handshake.
module unified_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = XLEN,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                IF_Req,
    input  logic [ADDR_W-1:0]   IF_Addr,
    input  logic                Flush,
    output logic                IF_Ready,
    output logic [DATA_W-1:0]   IF_Rdata,
    output logic                IF_Stall,
    input  logic                D_Req,
    input  logic                D_We,
    input  logic [ADDR_W-1:0]   D_Addr,
    input  logic [DATA_W-1:0]   D_Wdata,
    input  logic [DATA_W/8-1:0] D_Be,
    output logic                D_Ready,
    output logic [DATA_W-1:0]   D_Rdata,
    output logic                D_Stall,
    output logic                M_Req,
    output logic                M_We,
    output logic [ADDR_W-1:0]   M_Addr,
    output logic [DATA_W-1:0]   M_Wdata,
    output logic [DATA_W/8-1:0] M_Be,
    input  logic                M_Ack,
    input  logic [DATA_W-1:0]   M_Rdata
);

    localparam int BW = DATA_W / 8;

    arb_state_e        r_state, w_state;
    logic              r_mreq, w_mreq;
    logic              r_mwe, w_mwe;
    logic [ADDR_W-1:0] r_maddr, w_maddr;
    logic [DATA_W-1:0] r_mwdata, w_mwdata;
    logic [BW-1:0]     r_mbe, w_mbe;
    logic              r_if_ready, w_if_ready;
    logic              r_d_ready, w_d_ready;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
    logic              r_drop, w_drop;

    logic w_if_elig, w_d_elig, w_force_fetch;
    logic w_fetch_grant, w_data_grant;

    // A port is not re-granted in its own Ready cycle; a redirect masks fetch.
    assign w_if_elig = IF_Req & ~r_if_ready & ~Flush;
    assign w_d_elig  = D_Req & ~r_d_ready;

    arb_streak_cnt #(.MAX_DSTREAK(MAX_DSTREAK)) u_streak (
        .Clk           (Clk),
        .Rst           (Rst),
        .i_data_grant  (w_data_grant),
        .i_fetch_grant (w_fetch_grant),
        .i_if_req      (IF_Req),
        .o_force_fetch (w_force_fetch)
    );

    // State register and all registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_mreq     <= 1'b0;
            r_mwe      <= 1'b0;
            r_maddr    <= '0;
            r_mwdata   <= '0;
            r_mbe      <= '0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_mreq     <= w_mreq;
            r_mwe      <= w_mwe;
            r_maddr    <= w_maddr;
            r_mwdata   <= w_mwdata;
            r_mbe      <= w_mbe;
            r_if_ready <= w_if_ready;
            r_d_ready  <= w_d_ready;
            r_if_rdata <= w_if_rdata;
            r_d_rdata  <= w_d_rdata;
            r_drop     <= w_drop;
        end
    end

    // Next-state: arbitrate in IDLE, hold the request until M_Ack otherwise.
    always_comb begin
        w_state       = r_state;
        w_mreq        = r_mreq;
        w_mwe         = r_mwe;
        w_maddr       = r_maddr;
        w_mwdata      = r_mwdata;
        w_mbe         = r_mbe;
        w_if_ready    = 1'b0;
        w_d_ready     = 1'b0;
        w_if_rdata    = r_if_rdata;
        w_d_rdata     = r_d_rdata;
        w_drop        = r_drop;
        w_fetch_grant = 1'b0;
        w_data_grant  = 1'b0;
        case (r_state)
            IDLE: begin
                w_drop = 1'b0;
                if (w_if_elig && (!w_d_elig || w_force_fetch)) begin
                    w_fetch_grant = 1'b1;
                    w_state       = FETCH;
                    w_mreq        = 1'b1;
                    w_mwe         = 1'b0;
                    w_maddr       = IF_Addr;
                    w_mbe         = {BW{1'b1}};
                end else if (w_d_elig) begin
                    w_data_grant = 1'b1;
                    w_state      = DATA;
                    w_mreq       = 1'b1;
                    w_mwe        = D_We;
                    w_maddr      = D_Addr;
                    w_mwdata     = D_Wdata;
                    w_mbe        = D_Be;
                end
            end
            FETCH: begin
                if (Flush)
                    w_drop = 1'b1;
                if (M_Ack) begin
                    w_mreq  = 1'b0;
                    w_state = IDLE;
                    w_drop  = 1'b0;
                    // A redirect seen during or with the ack discards the word.
                    if (!(r_drop || Flush)) begin
                        w_if_ready = 1'b1;
                        w_if_rdata = M_Rdata;
                    end
                end
            end
            DATA: begin
                if (M_Ack) begin
                    w_mreq    = 1'b0;
                    w_state   = IDLE;
                    w_d_ready = 1'b1;
                    if (!r_mwe)
                        w_d_rdata = M_Rdata;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign IF_Ready = r_if_ready;
    assign IF_Rdata = r_if_rdata;
    assign D_Ready  = r_d_ready;
    assign D_Rdata  = r_d_rdata;
    assign M_Req    = r_mreq;
    assign M_We     = r_mwe;
    assign M_Addr   = r_maddr;
    assign M_Wdata  = r_mwdata;
    assign M_Be     = r_mbe;

    assign IF_Stall = IF_Req & ~r_if_ready;
    assign D_Stall  = D_Req & ~r_d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; inputs driven and outputs sampled
// 1 ns after the rising edge.
module tb_unified_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic        Flush;
    logic        IF_Ready;
    logic [31:0] IF_Rdata;
    logic        IF_Stall;
    logic        D_Req;
    logic        D_We;
    logic [31:0] D_Addr;
    logic [31:0] D_Wdata;
    logic [3:0]  D_Be;
    logic        D_Ready;
    logic [31:0] D_Rdata;
    logic        D_Stall;
    logic        M_Req;
    logic        M_We;
    logic [31:0] M_Addr;
    logic [31:0] M_Wdata;
    logic [3:0]  M_Be;
    logic        M_Ack;
    logic [31:0] M_Rdata;

    int total  = 0;
    int passed = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .Flush(Flush),
        .IF_Ready(IF_Ready), .IF_Rdata(IF_Rdata), .IF_Stall(IF_Stall),
        .D_Req(D_Req), .D_We(D_We), .D_Addr(D_Addr), .D_Wdata(D_Wdata), .D_Be(D_Be),
        .D_Ready(D_Ready), .D_Rdata(D_Rdata), .D_Stall(D_Stall),
        .M_Req(M_Req), .M_We(M_We), .M_Addr(M_Addr), .M_Wdata(M_Wdata), .M_Be(M_Be),
        .M_Ack(M_Ack), .M_Rdata(M_Rdata)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; IF_Req = 0; IF_Addr = 0; Flush = 0;
        D_Req = 0; D_We = 0; D_Addr = 0; D_Wdata = 0; D_Be = 0;
        M_Ack = 0; M_Rdata = 0;
        #2;
        total++; if ({M_Req, M_We, IF_Ready, D_Ready} !== 4'b0) $display("FAIL rst_ctrl got %b exp 0000", {M_Req, M_We, IF_Ready, D_Ready}); else passed++;
        total++; if ({M_Addr, M_Wdata, M_Be} !== 68'h0) $display("FAIL rst_mbus got %h exp 0", {M_Addr, M_Wdata, M_Be}); else passed++;
        total++; if ({IF_Rdata, D_Rdata} !== 64'h0) $display("FAIL rst_rdata got %h exp 0", {IF_Rdata, D_Rdata}); else passed++;
        step();
        Rst = 1'b0;
        step();
    endtask

    task automatic test_fetch_only();
        IF_Req = 1; IF_Addr = 32'h0000_0040;
        #1;
        total++; if (IF_Stall !== 1'b1) $display("FAIL t1_stall_c0 got %b exp 1", IF_Stall); else passed++;
        step();
        total++; if ({M_Req, M_We, M_Addr} !== {1'b1, 1'b0, 32'h40}) $display("FAIL t1_mreq got %b/%b/%h exp 1/0/40", M_Req, M_We, M_Addr); else passed++;
        total++; if (M_Be !== 4'hF) $display("FAIL t1_mbe got %h exp f", M_Be); else passed++;
        total++; if (IF_Stall !== 1'b1) $display("FAIL t1_stall_c1 got %b exp 1", IF_Stall); else passed++;
        M_Ack = 1; M_Rdata = 32'h2002_0005;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b1, 32'h2002_0005}) $display("FAIL t1_ready got %b/%h exp 1/20020005", IF_Ready, IF_Rdata); else passed++;
        total++; if ({IF_Stall, M_Req} !== 2'b00) $display("FAIL t1_stall_c2 got %b exp 00", {IF_Stall, M_Req}); else passed++;
        IF_Req = 0;
        step();
        total++; if (IF_Ready !== 1'b0) $display("FAIL t1_pulse got %b exp 0", IF_Ready); else passed++;
    endtask

    task automatic test_same_cycle();
        IF_Req = 1; IF_Addr = 32'h44;
        D_Req = 1; D_We = 0; D_Addr = 32'h100; D_Be = 4'hF;
        step();
        total++; if ({M_Req, M_We, M_Addr} !== {1'b1, 1'b0, 32'h100}) $display("FAIL t2_dfirst got %b/%b/%h exp 1/0/100", M_Req, M_We, M_Addr); else passed++;
        M_Ack = 1; M_Rdata = 32'h1111_2222;
        step();
        M_Ack = 0;
        total++; if ({D_Ready, D_Rdata} !== {1'b1, 32'h1111_2222}) $display("FAIL t2_dready got %b/%h exp 1/11112222", D_Ready, D_Rdata); else passed++;
        total++; if (IF_Stall !== 1'b1) $display("FAIL t2_stall got %b exp 1", IF_Stall); else passed++;
        D_Req = 0;
        step();
        total++; if ({M_Req, M_Addr, IF_Stall} !== {1'b1, 32'h44, 1'b1}) $display("FAIL t2_fetch got %b/%h/%b exp 1/44/1", M_Req, M_Addr, IF_Stall); else passed++;
        M_Ack = 1; M_Rdata = 32'h3333_4444;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata, IF_Stall} !== {1'b1, 32'h3333_4444, 1'b0}) $display("FAIL t2_iready got %b/%h/%b exp 1/33334444/0", IF_Ready, IF_Rdata, IF_Stall); else passed++;
        IF_Req = 0;
        step();
    endtask

    // Loads are re-presented immediately; fetch is masked with Flush only in
    // each D_Ready cycle so both ports meet in every arbitration slot.
    task automatic test_streak();
        bit exp_f [7];
        bit got_f [8];
        int ng = 0;
        int nd = 0;
        bit done = 0;
        exp_f = '{0, 0, 0, 0, 1, 0, 0};
        IF_Req = 1; IF_Addr = 32'h80;
        D_Req = 1; D_We = 0; D_Addr = 32'h400; D_Be = 4'hF;
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            step();
            M_Ack = 0; Flush = 0;
            if (M_Req) begin
                if (ng < 8) begin
                    got_f[ng] = (M_Addr == 32'h80) && !M_We;
                    ng++;
                end
                M_Ack = 1; M_Rdata = M_Addr ^ 32'hC0DE_0000;
            end
            if (D_Ready) begin
                nd++;
                if (nd == 6) D_Req = 0;
                else D_Addr = 32'h400 + 32'(nd * 4);
            end
            if (IF_Ready) IF_Req = 0;
            if (D_Ready && IF_Req) Flush = 1;
            if (nd == 6 && !IF_Req) done = 1;
        end
        Flush = 0; M_Ack = 0; IF_Req = 0; D_Req = 0;
        total++; if (!done || ng != 7) $display("FAIL t3_count got grants=%0d done=%0d exp 7/1", ng, done); else passed++;
        for (int i = 0; i < 7; i++) begin
            total++; if (got_f[i] !== exp_f[i]) $display("FAIL t3_order[%0d] got fetch=%0d exp %0d", i, got_f[i], exp_f[i]); else passed++;
        end
        total++; if (D_Rdata !== 32'hC0DE_0414) $display("FAIL t3_lastload got %h exp c0de0414", D_Rdata); else passed++;
        step();
    endtask

    task automatic test_flush();
        IF_Req = 1; IF_Addr = 32'h48;
        step();
        total++; if ({M_Req, M_Addr} !== {1'b1, 32'h48}) $display("FAIL t4_grant got %b/%h exp 1/48", M_Req, M_Addr); else passed++;
        step();
        Flush = 1;
        step();
        Flush = 0; IF_Addr = 32'h200;
        total++; if ({M_Req, M_Addr} !== {1'b1, 32'h48}) $display("FAIL t4_hold got %b/%h exp 1/48", M_Req, M_Addr); else passed++;
        step();
        M_Ack = 1; M_Rdata = 32'h0BAD_0BAD;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b0, 32'hC0DE_0080}) $display("FAIL t4_drop got %b/%h exp 0/c0de0080", IF_Ready, IF_Rdata); else passed++;
        step();
        total++; if ({M_Req, M_Addr} !== {1'b1, 32'h200}) $display("FAIL t4_regrant got %b/%h exp 1/200", M_Req, M_Addr); else passed++;
        M_Ack = 1; M_Rdata = 32'h0000_1234;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b1, 32'h0000_1234}) $display("FAIL t4_ready got %b/%h exp 1/00001234", IF_Ready, IF_Rdata); else passed++;
        IF_Req = 0;
        step();
    endtask

    task automatic test_flush_on_ack();
        IF_Req = 1; IF_Addr = 32'h60;
        step();
        M_Ack = 1; Flush = 1; M_Rdata = 32'hFFFF_0000;
        step();
        M_Ack = 0; Flush = 0; IF_Addr = 32'h64;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b0, 32'h0000_1234}) $display("FAIL t4b_drop got %b/%h exp 0/00001234", IF_Ready, IF_Rdata); else passed++;
        step();
        total++; if ({M_Req, M_Addr} !== {1'b1, 32'h64}) $display("FAIL t4b_regrant got %b/%h exp 1/64", M_Req, M_Addr); else passed++;
        M_Ack = 1; M_Rdata = 32'h0000_5678;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b1, 32'h0000_5678}) $display("FAIL t4b_ready got %b/%h exp 1/00005678", IF_Ready, IF_Rdata); else passed++;
        IF_Req = 0;
        step();
    endtask

    task automatic test_reset_mid_store();
        D_Req = 1; D_We = 1; D_Addr = 32'h300; D_Wdata = 32'hDEAD_BEEF; D_Be = 4'b0011;
        step();
        total++; if ({M_Req, M_We, M_Be} !== {1'b1, 1'b1, 4'b0011}) $display("FAIL t5_grant got %b/%b/%b exp 1/1/0011", M_Req, M_We, M_Be); else passed++;
        step();
        Rst = 1;
        #1;
        total++; if ({M_Req, M_We, D_Ready} !== 3'b000) $display("FAIL t5_async got %b exp 000", {M_Req, M_We, D_Ready}); else passed++;
        total++; if ({M_Addr, M_Be} !== 36'h0) $display("FAIL t5_clr got %h exp 0", {M_Addr, M_Be}); else passed++;
        step();
        Rst = 0;
        #1;
        total++; if ({M_Req, D_Ready, D_Stall} !== 3'b001) $display("FAIL t5_release got %b exp 001", {M_Req, D_Ready, D_Stall}); else passed++;
        step();
        total++; if ({M_Req, M_We, M_Addr, M_Wdata, M_Be} !== {1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011}) $display("FAIL t5_store got %b/%b/%h/%h/%b exp 1/1/300/deadbeef/0011", M_Req, M_We, M_Addr, M_Wdata, M_Be); else passed++;
        M_Ack = 1; M_Rdata = 32'h5555_AAAA;
        step();
        M_Ack = 0;
        total++; if ({D_Ready, D_Rdata} !== {1'b1, 32'h0}) $display("FAIL t5_done got %b/%h exp 1/0", D_Ready, D_Rdata); else passed++;
        D_Req = 0; D_We = 0;
        step();
    endtask

    task automatic test_stray_ack();
        M_Ack = 1; M_Rdata = 32'h1234_5678;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, D_Ready, M_Req} !== 3'b000) $display("FAIL t6_noready got %b exp 000", {IF_Ready, D_Ready, M_Req}); else passed++;
        total++; if ({IF_Rdata, D_Rdata} !== 64'h0) $display("FAIL t6_rdata got %h exp 0", {IF_Rdata, D_Rdata}); else passed++;
        IF_Req = 1; IF_Addr = 32'h10;
        step();
        total++; if ({M_Req, M_We, M_Addr} !== {1'b1, 1'b0, 32'h10}) $display("FAIL t6_idle got %b/%b/%h exp 1/0/10", M_Req, M_We, M_Addr); else passed++;
        M_Ack = 1; M_Rdata = 32'h0000_0013;
        step();
        M_Ack = 0;
        total++; if ({IF_Ready, IF_Rdata} !== {1'b1, 32'h13}) $display("FAIL t6_fetch got %b/%h exp 1/13", IF_Ready, IF_Rdata); else passed++;
        IF_Req = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_same_cycle();
        test_streak();
        test_flush();
        test_flush_on_ack();
        test_reset_mid_store();
        test_stray_ack();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
